// File: rtl/regfile_pkg.sv
// Shared widths and flattened-bus slice helpers for the tagged register file.
// Pure declarations: no logic, no latency, no flow control.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_NREAD  = 6;
  localparam int DEF_NWRITE = 3;

  // Low bit of element idx in a flattened bus of width-wide elements.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  // Width needed to name one of n ports; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_tagged_if.sv
// Bundle of read, dispatch-allocate and CDB write-back signals of the register file.
// Master drives addresses, alloc and write-backs; slave returns read data/status. No backpressure.
interface regfile_tagged_if #(
  parameter int DATA_W = regfile_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_pkg::DEF_ADDR_W,
  parameter int TAG_W  = regfile_pkg::DEF_TAG_W,
  parameter int NREAD  = regfile_pkg::DEF_NREAD,
  parameter int NWRITE = regfile_pkg::DEF_NWRITE
);

  logic [NREAD*ADDR_W-1:0]  raddr;
  logic [NREAD*DATA_W-1:0]  rdata;
  logic [NREAD-1:0]         rbusy;
  logic [NREAD*TAG_W-1:0]   rtag;

  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic [TAG_W-1:0]         alloc_tag;

  logic [NWRITE-1:0]        wen;
  logic [NWRITE*ADDR_W-1:0] waddr;
  logic [NWRITE*TAG_W-1:0]  wtag;
  logic [NWRITE*DATA_W-1:0] wdata;

  modport master (
    output raddr, alloc_en, alloc_addr, alloc_tag, wen, waddr, wtag, wdata,
    input  rdata, rbusy, rtag
  );

  modport slave (
    input  raddr, alloc_en, alloc_addr, alloc_tag, wen, waddr, wtag, wdata,
    output rdata, rbusy, rtag
  );

endinterface

// File: rtl/regfile_wb_resolve.sv
// Per-register write-back acceptance, winning CDB port and next busy/tag status.
// Purely combinational (0 cycles); stale-tag or not-busy writes are dropped, never stalled.
module regfile_wb_resolve
  import regfile_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int TAG_W  = DEF_TAG_W,
  parameter  int NWRITE = DEF_NWRITE,
  localparam int NREGS  = 2**ADDR_W,
  localparam int PIDX_W = idx_w(NWRITE)
) (
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*TAG_W-1:0]  wtag,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [TAG_W-1:0]         alloc_tag,
  input  logic [NREGS-1:0]         cur_busy,
  input  logic [NREGS*TAG_W-1:0]   cur_tag,
  output logic [NREGS-1:0]         wr_acc,
  output logic [NREGS*PIDX_W-1:0]  wr_port,
  output logic [NREGS-1:0]         nxt_busy,
  output logic [NREGS*TAG_W-1:0]   nxt_tag
);

  always_comb begin : resolve
    logic acc;
    acc      = 1'b0;
    wr_acc   = '0;
    wr_port  = '0;
    nxt_busy = cur_busy;
    nxt_tag  = cur_tag;
    for (int r = 0; r < NREGS; r++) begin
      acc = 1'b0;
      // Ascending scan: a later (higher) matching port overwrites the winner.
      for (int k = 0; k < NWRITE; k++) begin
        if (wen[k]
            && (waddr[slice_lo(k, ADDR_W) +: ADDR_W] == ADDR_W'(r))
            && cur_busy[r]
            && (cur_tag[slice_lo(r, TAG_W) +: TAG_W] == wtag[slice_lo(k, TAG_W) +: TAG_W])) begin
          acc = 1'b1;
          wr_port[slice_lo(r, PIDX_W) +: PIDX_W] = PIDX_W'(k);
        end
      end
      wr_acc[r] = acc;
      if (acc) begin
        nxt_busy[r] = 1'b0;
      end
      // A same-cycle allocation owns the status even if a write also landed.
      if (alloc_en && (alloc_addr == ADDR_W'(r))) begin
        nxt_busy[r] = 1'b1;
        nxt_tag[slice_lo(r, TAG_W) +: TAG_W] = alloc_tag;
      end
    end
  end

endmodule

// File: rtl/regfile_tagged.sv
// Tagged register file with busy/producer-tag status; reads 1 cycle after address, no backpressure.
// REGFILE_WRITE_BYPASS_EN additionally forwards same-cycle accepted writes and alloc status to reads.
module regfile_tagged
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int TAG_W  = DEF_TAG_W,
  parameter  int NREAD  = DEF_NREAD,
  parameter  int NWRITE = DEF_NWRITE,
  localparam int NREGS  = 2**ADDR_W,
  localparam int PIDX_W = idx_w(NWRITE)
) (
  input  logic             clk,
  input  logic             reset,
  regfile_tagged_if.slave  bus
);

  logic [DATA_W-1:0]       data_q [NREGS];
  logic [NREGS-1:0]        busy_q;
  logic [NREGS*TAG_W-1:0]  tag_q;
  logic [NREAD*ADDR_W-1:0] raddr_q;

  logic [NREGS-1:0]        wr_acc;
  logic [NREGS*PIDX_W-1:0] wr_port;
  logic [NREGS-1:0]        nxt_busy;
  logic [NREGS*TAG_W-1:0]  nxt_tag;
  logic [DATA_W-1:0]       wr_val [NREGS];

  logic [DATA_W-1:0]       view_data [NREGS];
  logic [NREGS-1:0]        view_busy;
  logic [NREGS*TAG_W-1:0]  view_tag;

  regfile_wb_resolve #(
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W),
    .NWRITE (NWRITE)
  ) u_resolve (
    .wen        (bus.wen),
    .waddr      (bus.waddr),
    .wtag       (bus.wtag),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .alloc_tag  (bus.alloc_tag),
    .cur_busy   (busy_q),
    .cur_tag    (tag_q),
    .wr_acc     (wr_acc),
    .wr_port    (wr_port),
    .nxt_busy   (nxt_busy),
    .nxt_tag    (nxt_tag)
  );

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_val[r] = bus.wdata[slice_lo(int'(wr_port[slice_lo(r, PIDX_W) +: PIDX_W]), DATA_W) +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= '0;
      end
      busy_q  <= '0;
      tag_q   <= '0;
      raddr_q <= '0;
    end else begin
      raddr_q <= bus.raddr;
      busy_q  <= nxt_busy;
      tag_q   <= nxt_tag;
      for (int r = 0; r < NREGS; r++) begin
        if (wr_acc[r]) begin
          data_q[r] <= wr_val[r];
        end
      end
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      view_data[r] = wr_acc[r] ? wr_val[r] : data_q[r];
    end
    view_busy = nxt_busy;
    view_tag  = nxt_tag;
  end
`else
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      view_data[r] = data_q[r];
    end
    view_busy = busy_q;
    view_tag  = tag_q;
  end
`endif

  always_comb begin : read_mux
    logic [ADDR_W-1:0] a;
    a         = '0;
    bus.rdata = '0;
    bus.rbusy = '0;
    bus.rtag  = '0;
    for (int i = 0; i < NREAD; i++) begin
      a = raddr_q[slice_lo(i, ADDR_W) +: ADDR_W];
      bus.rdata[slice_lo(i, DATA_W) +: DATA_W] = view_data[a];
      bus.rbusy[i]                             = view_busy[a];
      bus.rtag[slice_lo(i, TAG_W) +: TAG_W]    = view_tag[slice_lo(int'(a), TAG_W) +: TAG_W];
    end
  end

endmodule

// File: doc/regfile_tagged.md
Name: regfile_tagged

Overview:
- Parametrised architectural register file for the OoO core, replacing the fixed 8x16, 6-read/3-write file.
- Adds Tomasulo-style register status: per-register busy bit and producer tag.
- Dispatch allocates a destination; the CDB write-back ports commit data only when their tag matches the current producer.
- Read ports return data, busy and tag with one-cycle registered-address latency.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register index width; NREGS = 2**ADDR_W
- TAG_W, 4, producer (ROB/RS) tag width
- NREAD, 6, number of read ports
- NWRITE, 3, number of CDB write-back ports; lower index has lower priority

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- raddr  in  NREAD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  read data per port
- rbusy  out  NREAD  register busy (value pending) per port
- rtag  out  NREAD*TAG_W  producer tag per port, valid when rbusy=1
- alloc_en  in  1  dispatch allocates a destination register
- alloc_addr  in  ADDR_W  destination register
- alloc_tag  in  TAG_W  new producer tag
- wen  in  NWRITE  write-back valid per port
- waddr  in  NWRITE*ADDR_W  write-back register per port
- wtag  in  NWRITE*TAG_W  tag of producing instruction per port
- wdata  in  NWRITE*DATA_W  write-back data per port

Behaviour:
- State: data[NREGS], busy[NREGS], tag[NREGS], raddr_q[NREAD].
- Reset (sync, reset=1 at posedge): all data=0, busy=0, tag=0, raddr_q=0. Next cycle every rdata=0, rbusy=0, rtag=0. Reset overrides alloc and writes in the same cycle.
- Read latency 1: raddr_q<=raddr every edge. Outputs are combinational from data/busy/tag indexed by raddr_q.
  - Read result reflects every update committed at or before the edge that captured the address.
  - Updates at later edges appear in the following cycle; outputs are not held.
- Write acceptance per port k: accept when wen[k] && busy[waddr_k] && tag[waddr_k]==wtag_k, comparing pre-edge state.
  - Accepted: data<=wdata_k, busy<=0.
  - Not accepted (stale tag, or register not busy): no state change, silently dropped.
- Multiple accepted writes to the same register in one cycle: highest port index wins data; busy cleared once.
- Allocation: alloc_en sets busy[alloc_addr]<=1 and tag[alloc_addr]<=alloc_tag. Data is unchanged.
- Alloc and accepted write to the same register in the same cycle:
  - Write data is committed.
  - Alloc takes priority for status: busy stays 1, tag = alloc_tag.
- Re-allocating a busy register overwrites its tag; late writes carrying the old tag are then dropped.
- Writes and alloc to different registers are fully independent.
- No hardwired-zero register.

Optional Feature:
- Macro REGFILE_WRITE_BYPASS_EN.
- Defined: read outputs also forward same-cycle accepted writes.
  - If read port i has raddr_q==waddr_k of an accepted write, rdata_i=wdata_k (highest k wins) and rbusy_i=0, unless alloc to that register is also active, in which case rbusy_i=1 and rtag_i=alloc_tag.
  - Also forwards same-cycle alloc status when no write matches.
  - Adds combinational paths wdata/wen/alloc -> rdata/rbusy/rtag.
- Undefined: outputs are purely registered-state based, as described in Behaviour.

Decomposition:
- Package regfile_pkg: default widths, and the functions that compute the flattened-slice helper indices.
- Natural sub-module: regfile_wb_resolve. Combinational; per register it computes write-accept, winning port index and next busy/tag from wen/waddr/wtag, alloc and current status. It is reused by the bypass logic.
- Top holds storage and read muxes.

Test Plan:
- Reset then read all 8 regs via ports 0-5 -> rdata=0, rbusy=0, rtag=0 one cycle after address applied.
- Alloc r3 tag 5. Next cycle write port 0 r3 tag 5 data 0xBEEF. Read r3 -> cycle after alloc: rbusy=1, rtag=5. Cycle after write: rdata=0xBEEF, rbusy=0.
- Alloc r2 tag 1, then re-alloc r2 tag 7. Write r2 tag 1 data 0x1111 -> dropped: rdata unchanged, rbusy=1, rtag=7. Write tag 7 data 0x7777 -> accepted.
- r4 busy tag 2. Ports 0 and 2 both write r4 tag 2 (0xAAAA, 0xCCCC) same cycle -> r4=0xCCCC, busy=0.
- r5 busy tag 3. Same cycle: accepted write r5 0x5555 plus alloc r5 tag 9 -> data 0x5555, busy=1, tag=9.
- Mid-sequence reset with alloc_en and wen asserted -> all state zero. Under REGFILE_WRITE_BYPASS_EN: read r1 while writing r1 with matching tag -> new data visible in the same cycle.
